// File: rtl/accumulator_16bit_pkg.sv
// -----------------------------------------------------------------------------
// accumulator_16bit_pkg
// Shared definitions for the burst accumulator:
//   - state_t  : FSM state encoding (IDLE=0, ACC=1, DONE=2)
//   - WIDTH_DEF: default data/accumulator width (matches full_adder_16bit)
//   - CNT_W_DEF: default width of the burst length counter
// -----------------------------------------------------------------------------
package accumulator_16bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 8;

endpackage : accumulator_16bit_pkg

// File: rtl/full_adder_16bit.sv
// -----------------------------------------------------------------------------
// full_adder_16bit
// Purely combinational 16-bit ripple-carry adder built from one-bit full adders.
// Ports:
//   a    in  16  operand A
//   b    in  16  operand B
//   cin  in   1  carry in
//   sum  out 16  a + b + cin, modulo 2^16
//   cout out  1  carry out of bit 15
// -----------------------------------------------------------------------------
module full_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] w_carry;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi = gi + 1) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[16];

endmodule : full_adder_16bit

// File: rtl/accumulator_16bit.sv
// -----------------------------------------------------------------------------
// accumulator_16bit
// Accepts a burst of `len` words over a valid/ready handshake and sums them into
// a registered accumulator, one word per cycle, using full_adder_16bit with the
// accumulator fed back as operand A. Keeps sticky carry and signed-overflow
// flags and pulses `done` for one cycle when the burst completes.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin a burst (sampled only in IDLE)
//   len        in   CNT_W  burst length, sampled with start
//   in_valid   in   1      in_data valid
//   in_ready   out  1      word accepted this cycle when in_valid is high
//   in_data    in   WIDTH  operand word
//   acc_out    out  WIDTH  accumulator register
//   carry_flag out  1      sticky OR of adder carry-out over the burst
//   ovf_flag   out  1      sticky signed overflow over the burst
//   zero_flag  out  1      acc_out == 0
//   busy       out  1      high while accumulating
//   done       out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module accumulator_16bit
    import accumulator_16bit_pkg::*;
#(
    // The adder is fixed at 16 bits, so WIDTH must stay 16.
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] acc_out,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             zero_flag,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   acc_next;
    logic               r_carry;
    logic               carry_next;
    logic               r_ovf;
    logic               ovf_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   remaining_next;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_ovf_step;

    full_adder_16bit u_adder (
        .a    (r_acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Ready is a pure decode of the registered state, never of in_valid.
    assign in_ready = (r_state == ST_ACC);
    assign busy     = (r_state == ST_ACC);
    assign done     = (r_state == ST_DONE);
    assign w_accept = in_valid && in_ready;

    // Signed overflow: operands share a sign that the result does not.
    assign w_ovf_step = (r_acc[WIDTH-1] == in_data[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

    assign acc_out    = r_acc;
    assign carry_flag = r_carry;
    assign ovf_flag   = r_ovf;
    assign zero_flag  = (r_acc == '0);

    always_comb begin
        state_next     = r_state;
        acc_next       = r_acc;
        carry_next     = r_carry;
        ovf_next       = r_ovf;
        remaining_next = r_remaining;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    acc_next       = '0;
                    carry_next     = 1'b0;
                    ovf_next       = 1'b0;
                    remaining_next = len;
                    state_next     = (len == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (w_accept) begin
                    acc_next       = w_sum;
                    carry_next     = r_carry | w_cout;
                    ovf_next       = r_ovf | w_ovf_step;
                    remaining_next = r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= state_next;
            r_acc       <= acc_next;
            r_carry     <= carry_next;
            r_ovf       <= ovf_next;
            r_remaining <= remaining_next;
        end
    end

endmodule : accumulator_16bit

// File: tb/tb_accumulator_16bit.sv
// -----------------------------------------------------------------------------
// tb_accumulator_16bit
// Directed bench for accumulator_16bit with hand-computed expected sums.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_accumulator_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] acc_out;
    logic        carry_flag;
    logic        ovf_flag;
    logic        zero_flag;
    logic        busy;
    logic        done;

    int n_checks;
    int n_errors;
    int accept_cnt;
    int done_cnt;
    logic [15:0] vec [0:3];

    accumulator_16bit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .acc_out    (acc_out),
        .carry_flag (carry_flag),
        .ovf_flag   (ovf_flag),
        .zero_flag  (zero_flag),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and done events, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) accept_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " acc"},   32'(acc_out),    32'h0);
        check({tag, " carry"}, 32'(carry_flag), 32'h0);
        check({tag, " ovf"},   32'(ovf_flag),   32'h0);
        check({tag, " zero"},  32'(zero_flag),  32'h1);
        check({tag, " ready"}, 32'(in_ready),   32'h0);
        check({tag, " busy"},  32'(busy),       32'h0);
        check({tag, " done"},  32'(done),       32'h0);
    endtask

    // Pulse start for one edge; returns 1 ns into the following cycle.
    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 8'd0;
    endtask

    // Runs a burst of n words from vec[] with `gap` idle cycles between words,
    // then checks the result in the cycle after the last accept.
    task automatic run_burst(input string tag, input int n, input int gap,
                             input logic [15:0] exp_acc, input logic exp_c,
                             input logic exp_v);
        int d0;
        int a0;
        d0 = done_cnt;
        do_start(8'(n));
        check({tag, " ready after start"}, 32'(in_ready), 32'h1);
        check({tag, " busy after start"},  32'(busy),     32'h1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            tick();
            in_valid = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    a0 = accept_cnt;
                    tick();
                    check({tag, " no accept in gap"}, 32'(accept_cnt), 32'(a0));
                    check({tag, " ready in gap"},     32'(in_ready),   32'h1);
                end
            end
        end
        check({tag, " done"},  32'(done),       32'h1);
        check({tag, " busy"},  32'(busy),       32'h0);
        check({tag, " acc"},   32'(acc_out),    32'(exp_acc));
        check({tag, " carry"}, 32'(carry_flag), 32'(exp_c));
        check({tag, " ovf"},   32'(ovf_flag),   32'(exp_v));
        check({tag, " zero"},  32'(zero_flag),  32'(exp_acc == 16'h0));
        tick();
        check({tag, " done low"},  32'(done),     32'h0);
        check({tag, " acc hold"},  32'(acc_out),  32'(exp_acc));
        check({tag, " ready low"}, 32'(in_ready), 32'h0);
        check({tag, " one done"},  32'(done_cnt - d0), 32'h1);
        $display("burst %s: len=%0d acc=0x%04h c=%0d v=%0d z=%0d",
                 tag, n, acc_out, carry_flag, ovf_flag, zero_flag);
    endtask

    initial begin
        int d0;
        n_checks   = 0;
        n_errors   = 0;
        accept_cnt = 0;
        done_cnt   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        len        = 8'd0;
        in_valid   = 1'b0;
        in_data    = 16'h0;
        vec[0] = 16'h0; vec[1] = 16'h0; vec[2] = 16'h0; vec[3] = 16'h0;

        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Reset mid-burst: two of four words accepted, then asynchronous reset.
        do_start(8'd4);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_data  = 16'h0101;
        tick();
        in_valid = 1'b0;
        check("midburst acc before rst", 32'(acc_out), 32'h1335);
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst rst");
        $display("reset mid-burst: acc=0x%04h busy=%0d", acc_out, busy);
        tick();
        rst = 1'b0;
        tick();

        // Signed overflow, no carry, back-to-back words.
        vec[0] = 16'h158A; vec[1] = 16'h7095;
        run_burst("pos_ovf", 2, 0, 16'h861F, 1'b0, 1'b1);

        // len = 0: immediate done, accumulator cleared, never ready.
        do_start(8'd0);
        check("len0 done",  32'(done),     32'h1);
        check("len0 acc",   32'(acc_out),  32'h0);
        check("len0 ready", 32'(in_ready), 32'h0);
        check("len0 ovf",   32'(ovf_flag), 32'h0);
        tick();
        check("len0 done low", 32'(done),     32'h0);
        check("len0 ready2",   32'(in_ready), 32'h0);
        $display("burst len0: acc=0x%04h done_cnt=%0d", acc_out, done_cnt);

        // Carry and overflow both set.
        vec[0] = 16'hB903; vec[1] = 16'hC6BD;
        run_burst("neg_ovf", 2, 0, 16'h7FC0, 1'b1, 1'b1);

        // Gapped input wrapping to exactly zero.
        vec[0] = 16'h52AF; vec[1] = 16'h9A4E; vec[2] = 16'h1303;
        run_burst("gap_zero", 3, 2, 16'h0000, 1'b1, 1'b0);

        // start pulsed during ACC must be ignored.
        d0 = done_cnt;
        do_start(8'd2);
        start = 1'b1;
        len   = 8'd5;
        tick();
        start = 1'b0;
        len   = 8'd0;
        check("ignore start busy", 32'(busy), 32'h1);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        tick();
        in_data  = 16'h0002;
        tick();
        in_valid = 1'b0;
        check("ignore start done", 32'(done),    32'h1);
        check("ignore start acc",  32'(acc_out), 32'h0003);
        tick();
        tick();
        check("ignore start idle ready", 32'(in_ready), 32'h0);
        check("ignore start idle busy",  32'(busy),     32'h0);
        check("ignore start one done",   32'(done_cnt - d0), 32'h1);
        $display("burst ignore_start: acc=0x%04h", acc_out);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_accumulator_16bit

// File: doc/accumulator_16bit.md
# accumulator_16bit

Sequential accumulation stage wrapped around the existing `full_adder_16bit`. It accepts a burst of `len` 16-bit words over a valid/ready handshake and sums them into a registered accumulator, one word per cycle. It also keeps sticky carry and signed-overflow flags, then reports completion. It consumes the adder's `sum`/`cout` and feeds the registered result back as the adder's A operand.

## Interface
- `WIDTH`, 16, data/accumulator width (matches `full_adder_16bit`)
- `CNT_W`, 8, width of burst length counter
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  begin a new burst; sampled only in IDLE
- `len`  input  CNT_W  number of words in burst, sampled with `start`
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  block accepts a word this cycle
- `in_data`  input  WIDTH  operand word
- `acc_out`  output  WIDTH  accumulator value (registered)
- `carry_flag`  output  1  sticky OR of adder `cout` over the burst
- `ovf_flag`  output  1  sticky signed two's-complement overflow over the burst
- `zero_flag`  output  1  `acc_out == 0`
- `busy`  output  1  high in ACC
- `done`  output  1  one-cycle pulse in DONE

## Operation
- States: IDLE, ACC, DONE.
- IDLE:
  - `in_ready`=0.
  - `start`=1 with `len`>0 → ACC; `acc`←0, flags←0, `remaining`←`len`.
  - `start`=1 with `len`=0 → DONE; `acc`←0, flags←0.
- ACC:
  - `in_ready`=1. A word is accepted when `in_valid`&&`in_ready`.
  - On accept: `acc`←`sum` of the adder (A=`acc`, B=`in_data`, cin=0). `carry_flag`|=`cout`. `ovf_flag`|=(A[15]==B[15])&&(sum[15]!=A[15]). `remaining`←`remaining`−1.
  - Accept with `remaining`==1 → DONE.
  - `in_valid`=0 → hold all state; no timeout.
- DONE: `done`=1 for exactly one cycle, then unconditionally → IDLE.
- `acc_out` and flags hold after DONE until the next accepted `start`.
- `start` in ACC or DONE is ignored; it is not queued.
- Arithmetic: modulo 2^WIDTH. The result wraps silently; the flags record the events.
- `zero_flag` is combinational from the `acc` register.

## Timing
- Reset values: state=IDLE, `acc_out`=0, `carry_flag`=0, `ovf_flag`=0, `zero_flag`=1, `in_ready`=0, `busy`=0, `done`=0, `remaining`=0.
- `rst` asserted mid-burst returns all of the above immediately, asynchronously. Partial results are discarded.
- `start` at edge N → `in_ready`=1 from cycle N+1.
- Throughput is 1 word per cycle with `in_valid` held high.
- Accept at edge N → `acc_out`/flags updated in cycle N+1.
- Last accept at edge N → `done`=1 and final `acc_out` in cycle N+1. `busy`=0 in the same cycle.
- `len`=0: `start` at edge N → `done`=1 in cycle N+1, `acc_out`=0.
- `in_ready` decodes only from the registered state; it has no combinational path from `in_valid`.

## Structure
- A shared package/include holds the state encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the default `WIDTH`/`CNT_W`.
- One sub-module: the existing `full_adder_16bit`, instantiated unchanged with cin tied to 0. The accumulator register, counter, flags and FSM live in `accumulator_16bit`.

## Test plan
- Reset mid-burst: `len`=4, accept 2 words, assert `rst` → all outputs at reset values in the same cycle; a subsequent `start` works normally.
- `len`=2, words 0x158A, 0x7095 back-to-back → `acc_out`=0x861F, `carry_flag`=0, `ovf_flag`=1, `done` pulses once, 3 cycles after `start`.
- `len`=2, words 0xB903, 0xC6BD → `acc_out`=0x7FC0, `carry_flag`=1, `ovf_flag`=1.
- `len`=3, words 0x52AF, 0x9A4E, 0x1303 with `in_valid` gaps of 2 cycles → `acc_out`=0x0000, `zero_flag`=1, `carry_flag`=1, `ovf_flag`=0; no accept during gaps.
- `len`=0 → `done` the cycle after `start`, `acc_out`=0, `in_ready` never high.
- `start` pulsed during ACC → ignored; the burst completes with the original `len` and produces exactly one `done`.
